// File: rtl/dot_prod_feeder.sv
// Serial-to-vector feeder for dot_prod: packs a y reference vector once, then
// streams an x sliding window advanced by one sample per downstream handshake.
module dot_prod_feeder #(
  parameter int xi_bits = 12,
  parameter int xq_bits = 12,
  parameter int yi_bits = 12,
  parameter int yq_bits = 12,
  parameter int length  = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              m_axis_x_tvalid,
  input  logic signed [xi_bits-1:0]         xi_in,
  input  logic signed [xq_bits-1:0]         xq_in,
  output logic                              m_axis_x_tready,
  input  logic                              m_axis_y_tvalid,
  input  logic signed [yi_bits-1:0]         yi_in,
  input  logic signed [yq_bits-1:0]         yq_in,
  output logic                              m_axis_y_tready,
  input  logic                              y_reload,
  input  logic                              m_axis_product_tready,
  output logic                              s_axis_x_tvalid,
  output logic        [xi_bits*length-1:0]  xi,
  output logic        [xq_bits*length-1:0]  xq,
  output logic                              s_axis_y_tvalid,
  output logic        [yi_bits*length-1:0]  yi,
  output logic        [yq_bits*length-1:0]  yq
);

  localparam int cnt_bits = $clog2(length + 1);
  localparam logic [cnt_bits-1:0] CNT_LAST = cnt_bits'(length - 1);

  typedef enum logic [1:0] {LOAD_Y, FILL_X, STREAM} state_t;

  state_t              state, state_nxt;
  logic [cnt_bits-1:0] count;
  logic                x_vld, y_vld;
  logic                x_acc, y_acc, out_hs;

  assign x_acc           = m_axis_x_tvalid & m_axis_x_tready;
  assign y_acc           = m_axis_y_tvalid & m_axis_y_tready;
  assign out_hs          = x_vld & y_vld & m_axis_product_tready;
  assign s_axis_x_tvalid = x_vld;
  assign s_axis_y_tvalid = y_vld;

  always_comb begin
    state_nxt       = state;
    m_axis_x_tready = 1'b0;
    m_axis_y_tready = 1'b0;
    case (state)
      LOAD_Y: begin
        m_axis_y_tready = 1'b1;
        if (m_axis_y_tvalid && count == CNT_LAST) state_nxt = FILL_X;
      end
      FILL_X: begin
        m_axis_x_tready = 1'b1;
        if (m_axis_x_tvalid && count == CNT_LAST) state_nxt = STREAM;
      end
      STREAM: m_axis_x_tready = !x_vld || m_axis_product_tready;
      default: state_nxt = LOAD_Y;
    endcase
    // Reload and reset both refuse samples so nothing slips into a discarded vector.
    if (y_reload) begin
      state_nxt       = LOAD_Y;
      m_axis_x_tready = 1'b0;
      m_axis_y_tready = 1'b0;
    end
    if (reset) begin
      m_axis_x_tready = 1'b0;
      m_axis_y_tready = 1'b0;
    end
  end

  // Control: state, fill counter and output valids
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_Y;
      count <= '0;
      x_vld <= 1'b0;
      y_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (y_reload) begin
        count <= '0;
        x_vld <= 1'b0;
        y_vld <= 1'b0;
      end else begin
        case (state)
          LOAD_Y: if (y_acc) begin
            if (count == CNT_LAST) begin
              count <= '0;
              y_vld <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          FILL_X: if (x_acc) begin
            count <= count + 1'b1;
            if (count == CNT_LAST) x_vld <= 1'b1;
          end
          STREAM: begin
            if (x_acc)       x_vld <= 1'b1;
            else if (out_hs) x_vld <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Data: x window shifts toward element 0, y vector written in arrival order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xi <= '0;
      xq <= '0;
      yi <= '0;
      yq <= '0;
    end else begin
      if (x_acc) begin
        xi <= {xi_in, xi[xi_bits*length-1:xi_bits]};
        xq <= {xq_in, xq[xq_bits*length-1:xq_bits]};
      end
      if (y_acc) begin
        for (int k = 0; k < length; k++) begin
          if (count == cnt_bits'(k)) begin
            yi[k*yi_bits +: yi_bits] <= yi_in;
            yq[k*yq_bits +: yq_bits] <= yq_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed scoreboard bench for dot_prod_feeder: y load, x fill, stall,
// zero-bubble streaming, drain, reload and asynchronous reset.
module tb_dot_prod_feeder;
  localparam int B = 12;
  localparam int L = 5;

  logic clk = 1'b0;
  logic reset;
  logic m_axis_x_tvalid, m_axis_x_tready;
  logic signed [B-1:0] xi_in, xq_in, yi_in, yq_in;
  logic m_axis_y_tvalid, m_axis_y_tready;
  logic y_reload, m_axis_product_tready;
  logic s_axis_x_tvalid, s_axis_y_tvalid;
  logic [B*L-1:0] xi, xq, yi, yq;

  always #5 clk = ~clk;

  dot_prod_feeder #(.xi_bits(B), .xq_bits(B), .yi_bits(B), .yq_bits(B), .length(L)) dut (
    .clk(clk), .reset(reset),
    .m_axis_x_tvalid(m_axis_x_tvalid), .xi_in(xi_in), .xq_in(xq_in), .m_axis_x_tready(m_axis_x_tready),
    .m_axis_y_tvalid(m_axis_y_tvalid), .yi_in(yi_in), .yq_in(yq_in), .m_axis_y_tready(m_axis_y_tready),
    .y_reload(y_reload), .m_axis_product_tready(m_axis_product_tready),
    .s_axis_x_tvalid(s_axis_x_tvalid), .xi(xi), .xq(xq),
    .s_axis_y_tvalid(s_axis_y_tvalid), .yi(yi), .yq(yq)
  );

  int total = 0;
  int bad = 0;
  int xh[$];
  int yh[$];
  logic [2*B*L-1:0] x_sb[$];
  logic [2*B*L-1:0] y_sb[$];
  logic [2*B*L-1:0] last_x = '0;

  function automatic logic [B*L-1:0] pack_last(input int h[$], input bit neg);
    logic [B*L-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      v = h[h.size() - L + k];
      if (neg) v = -v;
      r[k*B +: B] = v[B-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [2*B*L-1:0] obs, input logic [2*B*L-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_y(input int v);
    int nv;
    logic [2*B*L-1:0] e;
    nv = -v;
    @(negedge clk);
    m_axis_y_tvalid = 1'b1;
    yi_in = v[B-1:0];
    yq_in = nv[B-1:0];
    #1;
    chk("y_tready_load", m_axis_y_tready, 1);
    chk("x_tready_load", m_axis_x_tready, 0);
    @(posedge clk);
    #1;
    m_axis_y_tvalid = 1'b0;
    yh.push_back(v);
    if (yh.size() == L) y_sb.push_back({pack_last(yh, 0), pack_last(yh, 1)});
    if (y_sb.size() > 0) begin
      e = y_sb.pop_front();
      chk("y_tvalid_full", s_axis_y_tvalid, 1);
      chk("y_vector", {yi, yq}, e);
    end else begin
      chk("y_tvalid_partial", s_axis_y_tvalid, 0);
    end
  endtask

  task automatic send_x(input int v, input bit exp_rdy);
    int nv;
    nv = -v;
    @(negedge clk);
    m_axis_x_tvalid = 1'b1;
    xi_in = v[B-1:0];
    xq_in = nv[B-1:0];
    #1;
    chk("x_tready", m_axis_x_tready, exp_rdy);
    @(posedge clk);
    #1;
    m_axis_x_tvalid = 1'b0;
    if (exp_rdy) begin
      xh.push_back(v);
      if (xh.size() >= L) x_sb.push_back({pack_last(xh, 0), pack_last(xh, 1)});
      if (x_sb.size() > 0) begin
        last_x = x_sb.pop_front();
        chk("x_tvalid_window", s_axis_x_tvalid, 1);
        chk("x_window", {xi, xq}, last_x);
      end else begin
        chk("x_tvalid_fill", s_axis_x_tvalid, 0);
      end
    end else begin
      chk("x_tvalid_held", s_axis_x_tvalid, 1);
      chk("x_window_held", {xi, xq}, last_x);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {xi, xq, yi, yq}, '0);
    chk({tag, "_valids"}, {s_axis_x_tvalid, s_axis_y_tvalid}, 0);
    chk({tag, "_treadys"}, {m_axis_x_tready, m_axis_y_tready}, 0);
  endtask

  initial begin
    reset = 1'b1;
    m_axis_x_tvalid = 1'b0; m_axis_y_tvalid = 1'b0;
    xi_in = '0; xq_in = '0; yi_in = '0; yq_in = '0;
    y_reload = 1'b0; m_axis_product_tready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("post_reset_y_tready", m_axis_y_tready, 1);

    // 1: y = 1..5
    for (int i = 1; i <= L; i++) send_y(i);

    // 2: fill x = 10..14 with downstream stalled, then hold
    for (int i = 10; i <= 14; i++) send_x(i, 1'b1);
    send_x(99, 1'b0);
    send_x(98, 1'b0);

    // 3: zero-bubble streaming
    m_axis_product_tready = 1'b1;
    for (int i = 15; i <= 17; i++) send_x(i, 1'b1);

    // 4: drain with no input: one handshake, then empty
    @(posedge clk);
    #1;
    chk("drain_tvalid", s_axis_x_tvalid, 0);
    chk("drain_window_kept", {xi, xq}, last_x);
    @(posedge clk);
    #1;
    chk("drain_tvalid_stays", s_axis_x_tvalid, 0);
    chk("drain_x_tready", m_axis_x_tready, 1);
    m_axis_product_tready = 1'b0;
    send_x(18, 1'b1);

    // 5: y_reload mid-STREAM
    @(negedge clk);
    y_reload = 1'b1;
    m_axis_x_tvalid = 1'b1;
    xi_in = 12'sd50;
    xq_in = -12'sd50;
    #1;
    chk("reload_x_tready", m_axis_x_tready, 0);
    chk("reload_y_tready", m_axis_y_tready, 0);
    @(posedge clk);
    #1;
    y_reload = 1'b0;
    m_axis_x_tvalid = 1'b0;
    #1;
    chk("reload_valids", {s_axis_x_tvalid, s_axis_y_tvalid}, 0);
    chk("reload_treadys", {m_axis_x_tready, m_axis_y_tready}, 2'b01);
    chk("reload_data_kept", {xi, xq}, last_x);
    xh.delete();
    yh.delete();
    for (int i = 0; i < L; i++) send_y(7);
    for (int i = 0; i <= 4; i++) send_x(i, 1'b1);

    // 6: asynchronous reset during FILL_X after 3 samples
    @(negedge clk);
    y_reload = 1'b1;
    @(negedge clk);
    y_reload = 1'b0;
    xh.delete();
    yh.delete();
    for (int i = 1; i <= L; i++) send_y(i);
    for (int i = 20; i <= 22; i++) send_x(i, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_reset_treadys", {m_axis_x_tready, m_axis_y_tready}, 2'b01);
    xh.delete();
    yh.delete();
    for (int i = 1; i <= L; i++) send_y(i + 100);
    send_x(40, 1'b1);

    if (x_sb.size() != 0 || y_sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", x_sb.size() + y_sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
